// File: rtl/i2s_transmitter.sv
// I2S master transmitter: 16-bit stereo pairs, 64-BCLK frames, one-pair holding buffer.
// Optional build macro I2S_TX_REPEAT_ON_UNDERRUN_EN: retransmit the last loaded pair on underrun.
module i2s_transmitter #(
  parameter int CLOCK_DIVISOR = 12,
  parameter int SAMPLE_WIDTH  = 16
) (
  input  logic                    clock_in,
  input  logic                    reset_in,
  input  logic [SAMPLE_WIDTH-1:0] left_sample_in,
  input  logic [SAMPLE_WIDTH-1:0] right_sample_in,
  input  logic                    sample_valid_in,
  output logic                    sample_ready_out,
  output logic                    i2s_bclk_out,
  output logic                    i2s_lrclk_out,
  output logic                    i2s_data_out,
  output logic                    frame_start_out,
  output logic                    underrun_out
);

  localparam logic [5:0] DIV_LAST    = 6'(CLOCK_DIVISOR - 1);
  localparam logic [5:0] LEFT_LAST   = 6'(SAMPLE_WIDTH);
  localparam logic [5:0] RIGHT_FIRST = 6'd33;
  localparam logic [5:0] RIGHT_LAST  = 6'(32 + SAMPLE_WIDTH);

  logic [5:0]              div_q, div_d;
  logic                    bclk_q, bclk_d;
  logic [5:0]              pos_q, pos_d;
  logic                    lrclk_q, lrclk_d;
  logic                    data_q, data_d;
  logic                    fs_q, fs_d;
  logic                    ur_q, ur_d;
  logic                    hold_full_q, hold_full_d;
  logic [SAMPLE_WIDTH-1:0] hold_l_q, hold_l_d;
  logic [SAMPLE_WIDTH-1:0] hold_r_q, hold_r_d;
  logic [SAMPLE_WIDTH-1:0] sh_l_q, sh_l_d;
  logic [SAMPLE_WIDTH-1:0] sh_r_q, sh_r_d;
`ifdef I2S_TX_REPEAT_ON_UNDERRUN_EN
  logic [SAMPLE_WIDTH-1:0] last_l_q, last_l_d;
  logic [SAMPLE_WIDTH-1:0] last_r_q, last_r_d;
`endif

  logic tick;
  logic fall;
  logic accept;

  always_comb begin
    div_d       = div_q;
    bclk_d      = bclk_q;
    pos_d       = pos_q;
    lrclk_d     = lrclk_q;
    data_d      = data_q;
    fs_d        = 1'b0;
    ur_d        = 1'b0;
    hold_full_d = hold_full_q;
    hold_l_d    = hold_l_q;
    hold_r_d    = hold_r_q;
    sh_l_d      = sh_l_q;
    sh_r_d      = sh_r_q;
`ifdef I2S_TX_REPEAT_ON_UNDERRUN_EN
    last_l_d    = last_l_q;
    last_r_d    = last_r_q;
`endif

    tick   = (div_q == DIV_LAST);
    fall   = tick && bclk_q;
    accept = sample_valid_in && !hold_full_q;

    if (tick) begin
      div_d  = '0;
      bclk_d = !bclk_q;
    end else begin
      div_d  = div_q + 6'd1;
    end

    if (accept) begin
      hold_l_d    = left_sample_in;
      hold_r_d    = right_sample_in;
      hold_full_d = 1'b1;
    end

    if (fall) begin
      pos_d   = pos_q + 6'd1;
      lrclk_d = pos_q[5];
      data_d  = 1'b0;
      if (pos_q == 6'd0) begin
        fs_d = 1'b1;
        // Load decision uses the pre-edge holding state; a same-edge accept waits a frame.
        if (hold_full_q) begin
          sh_l_d      = hold_l_q;
          sh_r_d      = hold_r_q;
          hold_full_d = 1'b0;
`ifdef I2S_TX_REPEAT_ON_UNDERRUN_EN
          last_l_d    = hold_l_q;
          last_r_d    = hold_r_q;
`endif
        end else begin
          ur_d = 1'b1;
`ifdef I2S_TX_REPEAT_ON_UNDERRUN_EN
          sh_l_d = last_l_q;
          sh_r_d = last_r_q;
`else
          sh_l_d = '0;
          sh_r_d = '0;
`endif
        end
      end else if (pos_q <= LEFT_LAST) begin
        data_d = sh_l_q[SAMPLE_WIDTH-1];
        sh_l_d = sh_l_q << 1;
      end else if (pos_q >= RIGHT_FIRST && pos_q <= RIGHT_LAST) begin
        data_d = sh_r_q[SAMPLE_WIDTH-1];
        sh_r_d = sh_r_q << 1;
      end
    end
  end

  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      div_q       <= '0;
      bclk_q      <= 1'b0;
      pos_q       <= '0;
      lrclk_q     <= 1'b0;
      data_q      <= 1'b0;
      fs_q        <= 1'b0;
      ur_q        <= 1'b0;
      hold_full_q <= 1'b0;
      hold_l_q    <= '0;
      hold_r_q    <= '0;
      sh_l_q      <= '0;
      sh_r_q      <= '0;
`ifdef I2S_TX_REPEAT_ON_UNDERRUN_EN
      last_l_q    <= '0;
      last_r_q    <= '0;
`endif
    end else begin
      div_q       <= div_d;
      bclk_q      <= bclk_d;
      pos_q       <= pos_d;
      lrclk_q     <= lrclk_d;
      data_q      <= data_d;
      fs_q        <= fs_d;
      ur_q        <= ur_d;
      hold_full_q <= hold_full_d;
      hold_l_q    <= hold_l_d;
      hold_r_q    <= hold_r_d;
      sh_l_q      <= sh_l_d;
      sh_r_q      <= sh_r_d;
`ifdef I2S_TX_REPEAT_ON_UNDERRUN_EN
      last_l_q    <= last_l_d;
      last_r_q    <= last_r_d;
`endif
    end
  end

  assign sample_ready_out = !hold_full_q;
  assign i2s_bclk_out     = bclk_q;
  assign i2s_lrclk_out    = lrclk_q;
  assign i2s_data_out     = data_q;
  assign frame_start_out  = fs_q;
  assign underrun_out     = ur_q;

endmodule

// File: tb/tb_i2s_transmitter.sv
// Scoreboard bench for i2s_transmitter: a frame-level model queues expected frames, a monitor checks the bus.
module tb_i2s_transmitter;
  localparam int CD    = 12;
  localparam int SW    = 16;
  localparam int FRAME = 64 * 2 * CD;
  localparam int FIRST = 2 * CD;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [SW-1:0] l_in = '0;
  logic [SW-1:0] r_in = '0;
  logic          v_in = 1'b0;
  logic          ready, bclk, lrclk, data, fs, ur;

  always #5 clk = ~clk;

  i2s_transmitter #(.CLOCK_DIVISOR(CD), .SAMPLE_WIDTH(SW)) dut (
    .clock_in        (clk),
    .reset_in        (rst),
    .left_sample_in  (l_in),
    .right_sample_in (r_in),
    .sample_valid_in (v_in),
    .sample_ready_out(ready),
    .i2s_bclk_out    (bclk),
    .i2s_lrclk_out   (lrclk),
    .i2s_data_out    (data),
    .frame_start_out (fs),
    .underrun_out    (ur)
  );

  typedef struct {
    int unsigned   n;
    logic [SW-1:0] l;
    logic [SW-1:0] r;
    logic          ur;
  } frame_t;

  frame_t        exp_q[$];
  int unsigned   cyc = 0;
  logic          m_full = 1'b0;
  logic [SW-1:0] m_hl = '0, m_hr = '0, m_last_l = '0, m_last_r = '0;
  int            tests = 0;
  int            fails = 0;

  function automatic void chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d, t=%0t)", name, got, exp, cyc, $time);
    end
  endfunction

  // Bit p of the frame as the bus should carry it: left MSB first at p=1, right at p=33.
  function automatic logic [63:0] frame_bits(input logic [SW-1:0] l, input logic [SW-1:0] r);
    logic [63:0] b;
    b = '0;
    for (int p = 1; p <= SW; p++) begin
      b[p]      = l[SW-p];
      b[32 + p] = r[SW-p];
    end
    return b;
  endfunction

  // Reference model: edge count since reset decides frame boundaries.
  logic   m_acc, m_load;
  frame_t m_f;
  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      cyc = 0; m_full = 1'b0; m_last_l = '0; m_last_r = '0;
      exp_q.delete();
    end else begin
      cyc++;
      m_acc  = v_in && !m_full;
      m_load = (cyc >= FIRST) && ((cyc - FIRST) % FRAME == 0);
      if (m_load) begin
        m_f.n = cyc;
        if (m_full) begin
          m_f.l = m_hl; m_f.r = m_hr; m_f.ur = 1'b0;
          m_last_l = m_hl; m_last_r = m_hr;
          m_full = 1'b0;
        end else begin
          m_f.ur = 1'b1;
`ifdef I2S_TX_REPEAT_ON_UNDERRUN_EN
          m_f.l = m_last_l; m_f.r = m_last_r;
`else
          m_f.l = '0; m_f.r = '0;
`endif
        end
        exp_q.push_back(m_f);
      end
      if (m_acc) begin
        m_hl = l_in; m_hr = r_in; m_full = 1'b1;
      end
    end
  end

  // Monitor: pops an expected frame at each frame_start and collects 64 bits on BCLK rises.
  logic        prev_bclk = 1'b0;
  logic        busy = 1'b0;
  int          cnt = 0;
  frame_t      cur;
  logic [63:0] got_d, got_lr;
  initial forever begin
    @(negedge clk);
    if (rst) begin
      busy = 1'b0; prev_bclk = 1'b0;
    end else begin
      chk("bclk", 64'(bclk), 64'((cyc / CD) % 2));
      chk("ready", 64'(ready), 64'(!m_full));
      if (ur && !fs) chk("underrun_without_frame_start", 64'(fs), 64'(1));
      if (fs) begin
        chk("frame_len", 64'(busy), 64'(0));
        if (exp_q.size() == 0) begin
          chk("unexpected_frame_start", 64'(fs), 64'(0));
          busy = 1'b0;
        end else begin
          cur = exp_q.pop_front();
          chk("frame_start_cycle", 64'(cyc), 64'(cur.n));
          chk("underrun", 64'(ur), 64'(cur.ur));
          busy = 1'b1; cnt = 0;
        end
      end
      if (busy && bclk && !prev_bclk) begin
        got_d[cnt]  = data;
        got_lr[cnt] = lrclk;
        cnt++;
        if (cnt == 64) begin
          chk("frame_data", got_d, frame_bits(cur.l, cur.r));
          chk("frame_lrclk", got_lr, 64'hFFFF_FFFF_0000_0000);
          busy = 1'b0;
        end
      end
      prev_bclk = bclk;
    end
  end

  task automatic idle_frames(input int k);
    v_in = 1'b0;
    repeat (k * FRAME) @(negedge clk);
  endtask

  task automatic send(input logic [SW-1:0] l, input logic [SW-1:0] r);
    @(negedge clk);
    v_in = 1'b1; l_in = l; r_in = r;
    @(negedge clk);
    v_in = 1'b0; l_in = SW'($urandom); r_in = SW'($urandom);
  endtask

  // Returns at the negedge where the edge count sits at the given offset from a frame boundary.
  task automatic wait_phase(input int unsigned ph);
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      if ((cyc + FRAME - FIRST) % FRAME == ph) return;
    end
    chk("wait_phase_timeout", 64'(0), 64'(1));
  endtask

  initial begin
    #(FRAME * 40 * 10);
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ready", 64'(ready), 64'(1));
    chk("rst_outputs", 64'({bclk, lrclk, data, fs, ur}), 64'(0));
    #1 rst = 1'b0;

    send(16'hA5C3, 16'h8001);
    idle_frames(2);

    send(16'h1234, 16'h5678);
    idle_frames(2);

    for (int i = 0; i < 4 * FRAME; i++) begin
      @(negedge clk);
      v_in = 1'b1; l_in = SW'($urandom); r_in = SW'($urandom);
    end
    v_in = 1'b0;

    for (int i = 0; i < 4 * FRAME; i++) begin
      @(negedge clk);
      v_in = ($urandom_range(0, 999) < 2); l_in = SW'($urandom); r_in = SW'($urandom);
    end
    v_in = 1'b0;

    idle_frames(1);
    wait_phase(FRAME - 1);
    v_in = 1'b1; l_in = 16'hBEEF; r_in = 16'h0F0F;
    @(negedge clk);
    v_in = 1'b0;
    idle_frames(2);

    send(16'h7FFF, 16'h8000);
    wait_phase(40 * 2 * CD + 6);
    chk("lrclk_p40", 64'(lrclk), 64'(1));
    #3 rst = 1'b1;
    #1;
    chk("async_rst_ready", 64'(ready), 64'(1));
    chk("async_rst_outputs", 64'({bclk, lrclk, data, fs, ur}), 64'(0));
    repeat (5) @(negedge clk);
    #2 rst = 1'b0;
    send(16'hC001, 16'h3FFE);
    idle_frames(3);

    @(negedge clk);
    #1;
    chk("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/i2s_transmitter.md
# i2s_transmitter

I2S master transmitter that serializes 16-bit stereo sample pairs onto an I2S bus for a DAC/amplifier. It runs from the 100 MHz system clock and generates its own BCLK and LRCLK using the same 64-BCLK frame timing as the microphone capture path, so playback and capture frames share a rate. The block buffers one sample pair behind a valid/ready handshake and signals underruns when no pair is queued at a frame boundary.

## Interface

- CLOCK_DIVISOR, 12: system clocks per BCLK half-period. BCLK period is 24 clocks, about 4.17 MHz. Legal range 2..63.
- SAMPLE_WIDTH, 16: bits per channel sample. Legal range 1..31.
- clock_in  input  1: 100 MHz system clock.
- reset_in  input  1: asynchronous, active-high reset.
- left_sample_in  input  SAMPLE_WIDTH: left sample, two's complement.
- right_sample_in  input  SAMPLE_WIDTH: right sample, two's complement.
- sample_valid_in  input  1: sample pair on the inputs is valid.
- sample_ready_out  output  1: holding register is empty and can accept a pair.
- i2s_bclk_out  output  1: bit clock.
- i2s_lrclk_out  output  1: word select; 0 selects left, 1 selects right.
- i2s_data_out  output  1: serial data, MSB first, one-BCLK I2S delay.
- frame_start_out  output  1: one-cycle pulse when a new frame begins.
- underrun_out  output  1: one-cycle pulse when a frame starts with no queued pair.

## Operation

- Divider counter runs 0..CLOCK_DIVISOR-1. When it reaches CLOCK_DIVISOR-1 (a "tick"), it wraps to 0 and i2s_bclk_out toggles.
- Rising tick: i2s_bclk_out goes 0 to 1. No other state changes.
- Falling tick: i2s_bclk_out goes 1 to 0. Frame position p (6 bits, 0..63) is used and then incremented, wrapping 63 to 0.
- At each falling tick with position p:
  - i2s_lrclk_out is set to p[5].
  - i2s_data_out is set to the next bit of the active shift register.
- Bit mapping within the frame:
  - p = 1..SAMPLE_WIDTH carries left bits MSB..LSB.
  - p = 33..32+SAMPLE_WIDTH carries right bits MSB..LSB.
  - All other positions carry 0, including p = 0 and p = 32 (the I2S delay slots).
- Frame load at the p = 0 falling tick:
  - If the holding register is full: its contents move into the left and right shift registers, the holding register is marked empty, and the pair is saved as "last loaded".
  - If the holding register is empty: underrun_out pulses and the zero (or repeat) pair is loaded.
  - frame_start_out pulses in both cases.
- Handshake:
  - sample_ready_out = NOT holding_full.
  - A transfer occurs on a clock where sample_valid_in and sample_ready_out are both 1. The pair is captured and holding_full is set.
  - Inputs are ignored when no transfer occurs.
- Simultaneous accept and load: the load decision uses holding_full as it was before that clock edge.
  - A pair accepted on the p = 0 falling tick while holding was empty counts as an underrun for this frame.
  - That pair is transmitted in the next frame.
- Queue capacity is one pair waiting plus one pair in flight. sample_ready_out stays low from an accept until the next p = 0 load.
- Reset (asynchronous, any time, including mid-frame):
  - Outputs: all outputs 0, except sample_ready_out which is 1.
  - Divider and p are 0; holding is empty; shift registers and last-loaded pair are 0.
  - A partial frame is abandoned, and no pulses are produced on reset exit.

## Timing

- All outputs are registered and change on the clock edge where the tick is detected.
- After reset deassertion:
  - The first rising tick is on the 12th clock edge.
  - The first falling tick (p = 0, first frame_start_out) is on the 24th clock edge (for CLOCK_DIVISOR = 12).
- Frame length: 64 × 2 × CLOCK_DIVISOR = 1536 clocks, about 65.1 kHz.
- Data and LRCLK change only on BCLK falling edges and are stable across BCLK rising edges.
- Latency: a pair accepted before a p = 0 tick has its left MSB driven one BCLK period (24 clocks) after that tick.
- sample_ready_out returns to 1 on the clock after the load tick.
- frame_start_out and underrun_out are high for exactly one clock.

## Configuration

- Macro: I2S_TX_REPEAT_ON_UNDERRUN_EN.
- Defined: on underrun, the last loaded pair is retransmitted. It is zero if no pair has been loaded since reset.
- Undefined: on underrun, a zero pair is transmitted.
- underrun_out pulses in both builds.

## Test plan

- Reset, no inputs: bclk period 24 clocks; lrclk period 1536 clocks with 768 low; data always 0; underrun_out and frame_start_out pulse every 1536 clocks.
- Send left = 0xA5C3 and right = 0x8001 before the first frame: the following frame reads left 1010010111000011 at p = 1..16 and right 1000000000000001 at p = 33..48. All other bits are 0 and underrun_out stays low.
- Hold sample_valid_in high continuously: exactly one accept per frame, ready low between accept and load, no underrun after the first frame.
- Present a pair exactly on the p = 0 falling tick with holding empty: underrun pulses for that frame and the pair is transmitted in the next frame.
- Load 0x1234/0x5678, then stop supplying: the next frame carries 0x1234/0x5678 when I2S_TX_REPEAT_ON_UNDERRUN_EN is defined and zeros when it is not; underrun_out pulses in both builds.
- Assert reset_in asynchronously at p = 40 (mid right slot): outputs go to their reset values immediately, and after release the timing restarts with the first p = 0 on the 24th edge.
